// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: host-loader and fetch port bundle for the instruction memory arbiter
interface imem_arbiter_if #(parameter int AW = 5, parameter int DW = 8);
    logic          load_mode;
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_gnt;
    logic          p0_rvalid;
    logic [DW-1:0] p0_rdata;
    logic          p1_req;
    logic [AW-1:0] p1_addr;
    logic          p1_gnt;
    logic          p1_rvalid;
    logic [DW-1:0] p1_rdata;
    logic [15:0]   conflict_cnt;
    modport master (
        output load_mode, p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_addr,
        input  p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata, conflict_cnt
    );
    modport slave (
        input  load_mode, p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_addr,
        output p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata, conflict_cnt
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin two-port arbiter owning the 2^AW x DW instruction memory
module imem_arbiter #(parameter int AW = 5, parameter int DW = 8) (
    input logic          clk,
    input logic          rst_n,
    imem_arbiter_if.slave bus
);
    logic [DW-1:0] mem_q [0:2**AW-1];
    logic          last_q, last_d;
    logic          p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
    logic [DW-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          p1_eff, both, g0, g1, rd0;
    always_comb begin
        p1_eff      = bus.p1_req & ~bus.load_mode;
        both        = bus.p0_req & p1_eff;
        g0          = ~rst_n & bus.p0_req & (~p1_eff | last_q);
        g1          = ~rst_n & p1_eff & (~bus.p0_req | ~last_q);
        rd0         = g0 & ~bus.p0_we;
        last_d      = g0 ? 1'b0 : g1 ? 1'b1 : last_q;
        p0_rvalid_d = rd0;
        p1_rvalid_d = g1;
        p0_rdata_d  = rd0 ? mem_q[bus.p0_addr] : p0_rdata_q;
        p1_rdata_d  = g1 ? mem_q[bus.p1_addr] : p1_rdata_q;
        cnt_d       = (both && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst_n) begin
            last_q      <= 1'b1;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            cnt_q       <= '0;
        end else begin
            last_q      <= last_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            cnt_q       <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (g0 && bus.p0_we) mem_q[bus.p0_addr] <= bus.p0_wdata;
    end
    // Reset masks a read return that is already in flight
    assign bus.p0_gnt       = g0;
    assign bus.p1_gnt       = g1;
    assign bus.p0_rvalid    = p0_rvalid_q & ~rst_n;
    assign bus.p1_rvalid    = p1_rvalid_q & ~rst_n;
    assign bus.p0_rdata     = p0_rdata_q;
    assign bus.p1_rdata     = p1_rdata_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: randomized scoreboard bench for imem_arbiter against a spec-level model
module tb_imem_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;
    typedef struct {int cyc; int data;} rd_t;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    imem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    imem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int   n_cmp = 0, n_bad = 0, cyc = 0, cnt_m = 0;
    bit   known = 0, p0_turn = 1, g0, g1;
    int   rd0_m = 0, rd1_m = 0;
    int   mem_m [32];
    rd_t  q0 [$], q1 [$];
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    task automatic step(input bit rst, input bit lm, input bit r0, input bit we, input int a0,
                        input int wd, input bit r1, input int a1, output bit x0, output bit x1);
        bit e1;
        @(posedge clk);
        #1;
        rst_n = rst;
        bus.load_mode = lm;
        bus.p0_req = r0;
        bus.p0_we = we;
        bus.p0_addr = a0[AW-1:0];
        bus.p0_wdata = wd[DW-1:0];
        bus.p1_req = r1;
        bus.p1_addr = a1[AW-1:0];
        #3;
        cyc++;
        e1 = r1 && !lm;
        x0 = !rst && r0 && (!e1 || p0_turn);
        x1 = !rst && e1 && !x0;
        chk("p0_gnt", int'(bus.p0_gnt), int'(x0));
        chk("p1_gnt", int'(bus.p1_gnt), int'(x1));
        if (known) begin
            chk("conflict_cnt", int'(bus.conflict_cnt), cnt_m);
            chk("p0_rdata_hold", int'(bus.p0_rdata), rd0_m);
            chk("p1_rdata_hold", int'(bus.p1_rdata), rd1_m);
        end
        if (rst) begin
            known = 1; p0_turn = 1; cnt_m = 0; rd0_m = 0; rd1_m = 0;
            q0.delete(); q1.delete();
        end else begin
            if (r0 && e1) cnt_m = (cnt_m == 65535) ? 65535 : cnt_m + 1;
            if (x0) p0_turn = 0;
            if (x1) p0_turn = 1;
            if (x0 && we) mem_m[a0] = wd;
            else if (x0) begin rd0_m = mem_m[a0]; q0.push_back(rd_t'{cyc + 1, mem_m[a0]}); end
            if (x1) begin rd1_m = mem_m[a1]; q1.push_back(rd_t'{cyc + 1, mem_m[a1]}); end
        end
    endtask
    task automatic mon(input bit p, input logic v, input int d);
        rd_t e;
        while ((p ? q1.size() : q0.size()) > 0 && (p ? q1[0].cyc : q0[0].cyc) < cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL p%0d_rvalid missing: got 0, expected 1 (cycle %0d)", p, cyc);
            if (p) void'(q1.pop_front()); else void'(q0.pop_front());
        end
        if (v) begin
            if ((p ? q1.size() : q0.size()) == 0 || (p ? q1[0].cyc : q0[0].cyc) != cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL p%0d_rvalid unexpected: got 1, expected 0 (cycle %0d)", p, cyc);
            end else begin
                e = p ? q1.pop_front() : q0.pop_front();
                chk(p ? "p1_rdata" : "p0_rdata", d, e.data);
            end
        end
    endtask
    initial forever begin
        @(negedge clk);
        if (known) begin
            mon(1'b0, bus.p0_rvalid, int'(bus.p0_rdata));
            mon(1'b1, bus.p1_rvalid, int'(bus.p1_rdata));
        end
    end
    initial begin
        bit p0p = 0, p1p = 0, w = 0, lm;
        int a0 = 0, a1 = 0, d = 0;
        int ld [4] = '{1, 5, 2, 3};
        rst_n = 1'b1;
        bus.load_mode = 0; bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0;
        bus.p0_wdata = '0; bus.p1_req = 0; bus.p1_addr = '0;
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        // Program load with fetch blocked, then fill the rest of the array
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, i, ld[i], 1, i, g0, g1);
        for (int i = 4; i < 32; i++) step(0, 1, 1, 1, i, $urandom_range(0, 255), 0, 0, g0, g1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, i, g0, g1);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 0, i, 0, 1, i + 8, g0, g1);
            chk("contention_order", int'(g0), int'(i % 2 == 0));
        end
        repeat (4) step(0, 1, 0, 0, 0, 0, 1, 9, g0, g1);
        step(0, 0, 0, 0, 0, 0, 1, 9, g0, g1);
        chk("lm_release_gnt", int'(g1), 1);
        step(0, 0, 1, 1, 7, 8'hAA, 0, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, 1, 7, g0, g1);
        step(0, 0, 0, 0, 0, 0, 1, 7, g0, g1);
        step(1, 0, 0, 0, 0, 0, 1, 7, g0, g1);
        chk("rst_p1_rvalid", int'(bus.p1_rvalid), 0);
        step(0, 0, 0, 0, 0, 0, 1, 7, g0, g1);
        step(0, 0, 1, 0, 3, 0, 1, 7, g0, g1);
        chk("post_rst_first_conflict_p0", int'(g0), 1);
        for (int i = 0; i < 400; i++) begin
            if (!p0p && $urandom_range(0, 2) != 0) begin
                p0p = 1; w = 1'($urandom_range(0, 1));
                a0 = $urandom_range(0, 31); d = $urandom_range(0, 255);
            end
            if (!p1p && $urandom_range(0, 2) != 0) begin p1p = 1; a1 = $urandom_range(0, 31); end
            lm = ($urandom_range(0, 4) == 0);
            step(($urandom_range(0, 99) == 0), lm, p0p, w, a0, d, p1p, a1, g0, g1);
            if (g0) p0p = 0;
            if (g1) p1p = 0;
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        for (int i = 0; i < 65540; i++) step(0, 0, 1, 0, i % 32, 0, 1, (i + 5) % 32, g0, g1);
        repeat (3) step(0, 0, 1, 0, 1, 0, 1, 2, g0, g1);
        chk("saturated_cnt", int'(bus.conflict_cnt), 65535);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        chk("p0_queue_drained", q0.size(), 0);
        chk("p1_queue_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter and controller for the 32 x 8 instruction memory of the accumulator core. Port 0 is the host program loader; port 1 is the core's fetch unit. The block owns the storage array, grants one access per cycle using round-robin arbitration, and returns read data one cycle after the grant. A load-mode input blocks fetch traffic while a program is being written.

## Interface

Parameters:
- AW, 5: address width; memory depth is 2^AW words.
- DW, 8: data width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-high (asserted = 1).
- load_mode  in  1  when 1, port 1 is never granted.
- p0_req  in  1  port 0 (host) access request.
- p0_we  in  1  port 0 access type: 1 = write, 0 = read.
- p0_addr  in  AW  port 0 address.
- p0_wdata  in  DW  port 0 write data.
- p0_gnt  out  1  port 0 access accepted this cycle.
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  DW  port 0 read data.
- p1_req  in  1  port 1 (fetch) read request; this port is read-only.
- p1_addr  in  AW  port 1 address.
- p1_gnt  out  1  port 1 access accepted this cycle.
- p1_rvalid  out  1  port 1 read data valid.
- p1_rdata  out  DW  port 1 read data.
- conflict_cnt  out  16  count of cycles in which both ports requested and one port was made to wait.

## Operation

- Storage: 2^AW x DW register array. Reset does not clear it.
- Arbitration:
  - gnt is combinational from req, load_mode, last_grant and rst_n.
  - Effective port 1 request: p1_req & ~load_mode.
  - Only one port requesting: that port is granted.
  - Both requesting: grant the port that is not last_grant.
  - No request: no grant.
  - last_grant is a 1-bit register, updated to the winner on every granted cycle and held otherwise.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt=1 in a cycle.
  - The access executes on the rising edge that ends the grant cycle.
  - If req stays high in the next cycle, that is a new request.
- Write (p0 only): mem[p0_addr] <= p0_wdata at the end of the grant cycle. No rvalid is produced.
- Read: the granted port's rdata register <= mem[addr] at the end of the grant cycle, and that port's rvalid = 1 for exactly the following cycle.
  - rdata holds its value until the next read for that port.
  - The other port's rdata/rvalid are unaffected.
- conflict_cnt:
  - Increments when both effective requests are high in a cycle.
  - Saturates at 0xFFFF.
  - A p1_req blocked by load_mode does not count.
- load_mode toggling mid-stream:
  - Takes effect in the same cycle.
  - A pending p1 request simply waits.
  - A read already granted still returns its rvalid.

## Timing

- Reset (rst_n=1 at a rising edge):
  - Registers: last_grant=1, so port 0 wins the first conflict. p0_rvalid=p1_rvalid=0, p0_rdata=p1_rdata=0, conflict_cnt=0.
  - While rst_n=1, p0_gnt=p1_gnt=0 and no memory access occurs.
- Reset asserted the cycle after a read grant: rvalid is forced to 0 and the read data is discarded.
- Latency:
  - gnt is in the same cycle as req when uncontended.
  - Read data is valid 1 cycle after gnt.
- Throughput:
  - One access per cycle in total.
  - A single requester holding req continuously is granted every cycle.
  - Two continuous requesters alternate 0,1,0,1…
- Read-after-write: a p0 write to A granted in cycle N, followed by a read of A (either port) granted in cycle N+1, returns the new data in cycle N+2.
- Same-cycle read and write of one address is impossible; only one grant exists per cycle.
- Address wrap: addresses are AW bits, so every value maps to a valid location and there is no out-of-range case.

## Test plan

- Load then fetch:
  - With load_mode=1, p0 writes 0x01,0x05,0x02,0x03 to addresses 0–3, and p0_gnt is 1 each cycle.
  - Then load_mode=0 and p1 reads addresses 0–3 back-to-back.
  - Required: p1_rvalid=1 on cycles 2–5 with rdata 0x01,0x05,0x02,0x03.
- Contention:
  - Both ports request continuously for 6 cycles.
  - Required: grants go p0,p1,p0,p1,p0,p1 and conflict_cnt=6.
- Load-mode block:
  - load_mode=1 with p1_req=1 for 4 cycles.
  - Required: p1_gnt=0 throughout and conflict_cnt unchanged.
  - After load_mode drops, p1_gnt=1 in the same cycle.
- Read-after-write: p0 writes 0xAA to address 7, then p1 reads address 7 in the next cycle. Required: p1_rdata=0xAA with p1_rvalid=1.
- Reset mid-operation:
  - Assert rst_n=1 in the cycle after a p1 read grant.
  - Required: p1_rvalid=0 and all counters and data are 0.
  - Memory contents are preserved, so a re-read returns the old value.
  - The first post-reset conflict is granted to p0.
- Counter saturation: force 65540 conflict cycles. Required: conflict_cnt=0xFFFF and stays there.
